// File: rtl/leaf_nic_if.sv
// leaf_nic_if: handshake bundle between a leaf NIC, its synchronous core and
// the asynchronous tree router.
//   tx_valid/tx_ready/tx_data : core -> NIC packet stream (valid/ready)
//   out_req/out_ack/out_data  : NIC -> router 4-phase bundled-data channel
//   in_req/in_ack/in_data     : router -> NIC 4-phase bundled-data channel
//   rx_valid/rx_ready/rx_data : NIC -> core packet stream (valid/ready)
// slave is the NIC's view; master is the view of the core/router side.
interface leaf_nic_if #(
    parameter int WIDTH = 11
);
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             out_req;
    logic             out_ack;
    logic [WIDTH-1:0] out_data;
    logic             in_req;
    logic             in_ack;
    logic [WIDTH-1:0] in_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;

    modport slave (
        input  tx_valid, tx_data, out_ack, in_req, in_data, rx_ready,
        output tx_ready, out_req, out_data, in_ack, rx_valid, rx_data
    );

    modport master (
        output tx_valid, tx_data, out_ack, in_req, in_data, rx_ready,
        input  tx_ready, out_req, out_data, in_ack, rx_valid, rx_data
    );
endinterface

// File: rtl/leaf_nic.sv
// leaf_nic: clocked network interface at a leaf of the asynchronous tree
// router. Core packets are queued in a TX FIFO and sent to the router as
// 4-phase bundled data; 4-phase packets from the router are captured into a
// single valid/ready output register. Packets pass through unmodified.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : leaf_nic_if.slave (tx_*, out_*, in_*, rx_* handshakes)
//   tx_level   : TX FIFO occupancy
//   tx_cnt     : packets completed on out_* (wraps)
//   rx_cnt     : packets accepted on in_* (wraps)
module leaf_nic #(
    parameter int WIDTH       = 11,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    leaf_nic_if.slave              bus,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [CNT_W-1:0]       tx_cnt,
    output logic [CNT_W-1:0]       rx_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
    typedef enum logic       {R_IDLE, R_ACK}        rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push, pop;

    // Ready comes only from registered occupancy, so a pop while full cannot
    // open the door for a push in the same cycle.
    assign bus.tx_ready = rst_n && (level != LVL_W'(DEPTH));
    assign push         = bus.tx_valid && bus.tx_ready;
    assign tx_level     = level;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------- synchronizers ----------------
    logic [SYNC_STAGES-1:0] ack_sync, req_sync;
    logic                   ack_s, req_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
            req_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.out_ack};
            req_sync <= {req_sync[SYNC_STAGES-2:0], bus.in_req};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign req_s = req_sync[SYNC_STAGES-1];

    // ---------------- TX FSM ----------------
    tx_state_t        t_state, t_next;
    logic             out_req_q, out_req_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state    <= T_IDLE;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            tx_cnt_q   <= '0;
        end else begin
            t_state    <= t_next;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // The FIFO head is popped on the ack edge but out_data stays registered,
    // so the bundle stays stable through the return-to-zero phase.
    always_comb begin
        t_next     = t_state;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        tx_cnt_d   = tx_cnt_q;
        pop        = 1'b0;
        unique case (t_state)
            T_IDLE: if (level != '0) begin
                out_data_d = mem[rd_ptr];
                out_req_d  = 1'b1;
                t_next     = T_REQ;
            end
            T_REQ: if (ack_s) begin
                out_req_d = 1'b0;
                pop       = 1'b1;
                tx_cnt_d  = tx_cnt_q + CNT_W'(1);
                t_next    = T_REL;
            end
            T_REL: if (!ack_s) t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase
    end

    assign bus.out_req  = out_req_q;
    assign bus.out_data = out_data_q;
    assign tx_cnt       = tx_cnt_q;

    // ---------------- RX FSM ----------------
    rx_state_t        r_state, r_next;
    logic             in_ack_q, in_ack_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= R_IDLE;
            in_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_cnt_q   <= '0;
        end else begin
            r_state    <= r_next;
            in_ack_q   <= in_ack_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    // Consumption clears rx_valid first; a capture on the same edge overrides
    // it, so the output register refills without a bubble.
    always_comb begin
        r_next     = r_state;
        in_ack_d   = in_ack_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        rx_cnt_d   = rx_cnt_q;
        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        unique case (r_state)
            R_IDLE: if (req_s && (!rx_valid_q || bus.rx_ready)) begin
                rx_data_d  = bus.in_data;
                rx_valid_d = 1'b1;
                in_ack_d   = 1'b1;
                rx_cnt_d   = rx_cnt_q + CNT_W'(1);
                r_next     = R_ACK;
            end
            R_ACK: if (!req_s) begin
                in_ack_d = 1'b0;
                r_next   = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign bus.in_ack   = in_ack_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign rx_cnt       = rx_cnt_q;
endmodule
